// File: rtl/global_defs.sv
// Global matrix/element dimensions shared by the MPU blocks.
// Not overridable per instance.
package global_defs;

  localparam int FP              = 32;
  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int MATRIX_REG_SIZE = 3;

endpackage

// File: rtl/mpu_pkg.sv
// MPU shared types: store- and load-path FSM state encodings.
// Imported by the load/store engines.
package mpu_pkg;

  typedef enum logic [1:0] {
    STORE_IDLE,
    STORE_MATRIX,
    STORE_DONE
  } store_state_t;

  typedef enum logic [1:0] {
    LOAD_IDLE,
    LOAD_MATRIX,
    LOAD_DONE
  } load_state_t;

endpackage

// File: rtl/mpu_load_walker.sv
// Row-major row/column pointer walker for the matrix load engine.
// last flags the (m-1, n-1) position using full-width size compares.
module mpu_load_walker
  import global_defs::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  input  logic [MBITS:0] m_size_i,
  input  logic [NBITS:0] n_size_i,
  output logic [MBITS:0] row,
  output logic [NBITS:0] col,
  output logic           last
);

  localparam logic [MBITS:0] ONE_M = {{MBITS{1'b0}}, 1'b1};
  localparam logic [NBITS:0] ONE_N = {{NBITS{1'b0}}, 1'b1};

  logic [MBITS:0] row_q, row_d;
  logic [NBITS:0] col_q, col_d;
  logic [MBITS:0] m_last;
  logic [NBITS:0] n_last;
  logic           col_end;

  assign m_last  = m_size_i - ONE_M;
  assign n_last  = n_size_i - ONE_N;
  assign col_end = (col_q == n_last);
  assign last    = (row_q == m_last) && col_end;

  // Next pointer: wrap col at n-1, and park at 0 after the final beat.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (last) begin
        row_d = '0;
        col_d = '0;
      end else if (col_end) begin
        row_d = row_q + ONE_M;
        col_d = '0;
      end else begin
        col_d = col_q + ONE_N;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/mpu_load.sv
// Matrix load engine: memory beats -> register file, row-major.
// Optional start-size rejection via MPU_LOAD_SIZE_CHECK_EN.
module mpu_load
  import global_defs::*;
  import mpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en_in,
  input  logic [MATRIX_REG_SIZE-1:0] mem_load_addr_in,
  input  logic [MBITS:0]             mem_m_load_size_in,
  input  logic [NBITS:0]             mem_n_load_size_in,
  input  logic [FP-1:0]              mem_load_element_in,
  input  logic                       mem_load_valid_in,
  output logic                       mem_load_ready_out,
  output logic                       reg_load_en_out,
  output logic [FP-1:0]              reg_load_element_out,
  output logic [MBITS:0]             reg_i_load_loc_out,
  output logic [NBITS:0]             reg_j_load_loc_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
  output logic [MBITS:0]             reg_m_load_size_out,
  output logic [NBITS:0]             reg_n_load_size_out,
  output logic                       load_busy_out,
  output logic                       load_done_out,
  output logic                       load_error_out
);

  load_state_t state_q, state_d;

  logic [MATRIX_REG_SIZE-1:0] addr_q;
  logic [MBITS:0]             m_q;
  logic [NBITS:0]             n_q;
  logic                       wen_q;
  logic [FP-1:0]              elem_q;
  logic [MBITS:0]             i_q;
  logic [NBITS:0]             j_q;

  logic           req;
  logic           size_bad;
  logic           start;
  logic           accept;
  logic [MBITS:0] row;
  logic [NBITS:0] col;
  logic           last;

  assign req = (state_q == LOAD_IDLE) && load_en_in;

`ifdef MPU_LOAD_SIZE_CHECK_EN
  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

  logic err_q;

  assign size_bad = (mem_m_load_size_in == '0)
                 || (mem_n_load_size_in == '0)
                 || (mem_m_load_size_in > M_MAX)
                 || (mem_n_load_size_in > N_MAX);

  // One-cycle pulse after a rejected start.
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= req && size_bad;
  end

  assign load_error_out = err_q;
`else
  assign size_bad       = 1'b0;
  assign load_error_out = 1'b0;
`endif

  assign start  = req && !size_bad;
  assign accept = (state_q == LOAD_MATRIX) && mem_load_valid_in;

  mpu_load_walker u_walker (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .advance  (accept),
    .m_size_i (m_q),
    .n_size_i (n_q),
    .row      (row),
    .col      (col),
    .last     (last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= LOAD_IDLE;
    else      state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d            = state_q;
    mem_load_ready_out = 1'b0;
    load_busy_out      = 1'b0;
    load_done_out      = 1'b0;
    unique case (state_q)
      LOAD_IDLE: begin
        if (start) state_d = LOAD_MATRIX;
      end
      LOAD_MATRIX: begin
        mem_load_ready_out = 1'b1;
        load_busy_out      = 1'b1;
        if (accept && last) state_d = LOAD_DONE;
      end
      LOAD_DONE: begin
        load_busy_out = 1'b1;
        load_done_out = 1'b1;
        state_d       = LOAD_IDLE;
      end
      default: state_d = LOAD_IDLE;
    endcase
  end

  // Captured job parameters, held until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      m_q    <= '0;
      n_q    <= '0;
    end else if (start) begin
      addr_q <= mem_load_addr_in;
      m_q    <= mem_m_load_size_in;
      n_q    <= mem_n_load_size_in;
    end
  end

  // Register-file write port, one cycle behind each accepted beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wen_q  <= 1'b0;
      elem_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else begin
      wen_q <= accept;
      if (accept) begin
        elem_q <= mem_load_element_in;
        i_q    <= row;
        j_q    <= col;
      end
    end
  end

  assign reg_load_en_out      = wen_q;
  assign reg_load_element_out = elem_q;
  assign reg_i_load_loc_out   = i_q;
  assign reg_j_load_loc_out   = j_q;
  assign reg_load_addr_out    = addr_q;
  assign reg_m_load_size_out  = m_q;
  assign reg_n_load_size_out  = n_q;

endmodule

// File: tb/tb_mpu_load.sv
// Directed self-checking bench for mpu_load.
// Size-rejection steps build only with MPU_LOAD_SIZE_CHECK_EN.
module tb_mpu_load;
  import global_defs::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       load_en;
  logic [MATRIX_REG_SIZE-1:0] addr;
  logic [MBITS:0]             m_in;
  logic [NBITS:0]             n_in;
  logic [FP-1:0]              elem;
  logic                       valid;
  logic                       ready;
  logic                       wen;
  logic [FP-1:0]              welem;
  logic [MBITS:0]             wi;
  logic [NBITS:0]             wj;
  logic [MATRIX_REG_SIZE-1:0] waddr;
  logic [MBITS:0]             wm;
  logic [NBITS:0]             wn;
  logic                       busy;
  logic                       done;
  logic                       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpu_load dut (
    .clk                  (clk),
    .rst                  (rst),
    .load_en_in           (load_en),
    .mem_load_addr_in     (addr),
    .mem_m_load_size_in   (m_in),
    .mem_n_load_size_in   (n_in),
    .mem_load_element_in  (elem),
    .mem_load_valid_in    (valid),
    .mem_load_ready_out   (ready),
    .reg_load_en_out      (wen),
    .reg_load_element_out (welem),
    .reg_i_load_loc_out   (wi),
    .reg_j_load_loc_out   (wj),
    .reg_load_addr_out    (waddr),
    .reg_m_load_size_out  (wm),
    .reg_n_load_size_out  (wn),
    .load_busy_out        (busy),
    .load_done_out        (done),
    .load_error_out       (err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int a, input int m, input int n);
    load_en = 1'b1;
    addr    = MATRIX_REG_SIZE'(a);
    m_in    = (MBITS+1)'(m);
    n_in    = (NBITS+1)'(n);
    @(negedge clk);
    load_en = 1'b0;
    chk("st_busy", busy, 1);
    chk("st_ready", ready, 1);
    chk("st_wen", wen, 0);
    chk("st_addr", waddr, a);
    chk("st_m", wm, m);
    chk("st_n", wn, n);
    chk("st_err", err, 0);
  endtask

  task automatic beat(input logic [31:0] e, input int i,
                      input int j, input bit lst);
    valid = 1'b1;
    elem  = e;
    @(negedge clk);
    valid = 1'b0;
    chk("wr_en", wen, 1);
    chk("wr_elem", welem, e);
    chk("wr_i", wi, i);
    chk("wr_j", wj, j);
    chk("wr_done", done, lst);
  endtask

  task automatic stall();
    valid = 1'b0;
    @(negedge clk);
    chk("stl_wen", wen, 0);
    chk("stl_ready", ready, 1);
    chk("stl_done", done, 0);
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_wen", wen, 0);
    chk("end_ready", ready, 0);
  endtask

  task automatic zero_chk();
    chk("z_ready", ready, 0);
    chk("z_wen", wen, 0);
    chk("z_elem", welem, 0);
    chk("z_i", wi, 0);
    chk("z_j", wj, 0);
    chk("z_addr", waddr, 0);
    chk("z_m", wm, 0);
    chk("z_n", wn, 0);
    chk("z_busy", busy, 0);
    chk("z_done", done, 0);
    chk("z_err", err, 0);
  endtask

  initial begin
    rst     = 1'b0;
    load_en = 1'b0;
    addr    = '0;
    m_in    = '0;
    n_in    = '0;
    elem    = '0;
    valid   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    zero_chk();
    rst = 1'b1;
    @(negedge clk);

    // 2x3, valid held high, elements 1.0 .. 6.0
    start(5, 2, 3);
    beat(32'h3f800000, 0, 0, 0);
    beat(32'h40000000, 0, 1, 0);
    beat(32'h40400000, 0, 2, 0);
    beat(32'h40800000, 1, 0, 0);
    beat(32'h40a00000, 1, 1, 0);
    beat(32'h40c00000, 1, 2, 1);
    chk("23_m_hold", wm, 2);
    idle_chk();
    chk("23_n_hold", wn, 3);

    // 2x2 with a 3-cycle stall after beat 1
    start(2, 2, 2);
    beat(32'h00000011, 0, 0, 0);
    stall();
    stall();
    stall();
    beat(32'h00000022, 0, 1, 0);
    beat(32'h00000033, 1, 0, 0);
    beat(32'h00000044, 1, 1, 1);
    idle_chk();

    // 1x1
    start(4, 1, 1);
    beat(32'hdeadbeef, 0, 0, 1);
    idle_chk();

    // reset in the middle of a 4x4
    start(1, 4, 4);
    beat(32'h00000001, 0, 0, 0);
    beat(32'h00000002, 0, 1, 0);
    beat(32'h00000003, 0, 2, 0);
    beat(32'h00000004, 0, 3, 0);
    beat(32'h00000005, 1, 0, 0);
    rst   = 1'b0;
    valid = 1'b1;
    elem  = 32'h00000006;
    @(negedge clk);
    zero_chk();
    rst   = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    chk("rs_done", done, 0);
    chk("rs_busy", busy, 0);
    start(6, 1, 2);
    beat(32'h12345678, 0, 0, 0);
    beat(32'h9abcdef0, 0, 1, 1);
    idle_chk();

    // load_en pulsed while loading is ignored
    start(3, 2, 2);
    beat(32'h000000a1, 0, 0, 0);
    load_en = 1'b1;
    addr    = 3'd7;
    m_in    = 3'd1;
    n_in    = 3'd1;
    stall();
    load_en = 1'b0;
    chk("ig_addr", waddr, 3);
    chk("ig_m", wm, 2);
    chk("ig_n", wn, 2);
    beat(32'h000000a2, 0, 1, 0);
    beat(32'h000000a3, 1, 0, 0);
    beat(32'h000000a4, 1, 1, 1);
    chk("ig_addr2", waddr, 3);
    idle_chk();
    idle_chk();

`ifdef MPU_LOAD_SIZE_CHECK_EN
    // rejected starts: m=0, then m=M+1
    load_en = 1'b1;
    addr    = 3'd5;
    m_in    = 3'd0;
    n_in    = 3'd2;
    @(negedge clk);
    load_en = 1'b0;
    chk("e0_err", err, 1);
    chk("e0_busy", busy, 0);
    chk("e0_wen", wen, 0);
    chk("e0_m", wm, 2);
    @(negedge clk);
    chk("e0_pulse", err, 0);
    chk("e0_busy2", busy, 0);
    load_en = 1'b1;
    m_in    = 3'd5;
    n_in    = 3'd2;
    @(negedge clk);
    load_en = 1'b0;
    chk("e5_err", err, 1);
    chk("e5_busy", busy, 0);
    chk("e5_wen", wen, 0);
    @(negedge clk);
    chk("e5_pulse", err, 0);
    chk("e5_wen2", wen, 0);

    // full MxN load is accepted
    start(7, M, N);
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        beat(32'(r * 16 + c), r, c,
             (r == M - 1) && (c == N - 1));
      end
    end
    idle_chk();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
